// File: rtl/uart_host_sequencer.sv
// rtl/uart_host_sequencer.sv - host-side UART command sequencer for the debug link
//
// Turns one queued operation at a time into byte traffic on a uart_tx/uart_rx pair:
// send a byte, send a word LSB-first, collect N bytes, or wait for the ready char.
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready  command handshake (ready only in IDLE)
//   i_cmd_op                 0 SEND_BYTE, 1 SEND_WORD, 2 RECV_N, 3 WAIT_READY
//   i_cmd_data, i_cmd_len    payload for sends, byte count for RECV_N
//   o_tx_start, o_tx_data    byte request towards uart_tx, held until i_tx_done
//   i_tx_done                one-cycle completion pulse from uart_tx
//   i_rx_valid, i_rx_data    one-cycle received byte from uart_rx
//   o_rx_byte_valid, o_rx_byte, o_rx_index   forwarded byte and its position
//   o_done, o_timeout        completion pulse, qualified by timeout flag
//   o_busy                   high whenever not IDLE

module uart_host_sequencer #(
   parameter int         WORD_WIDTH     = 32,
   parameter int         MAX_RX_BYTES   = 128,
   parameter logic [7:0] READY_CHAR     = 8'h52,
   parameter int         TIMEOUT_CYCLES = 0
) (
   input  logic                                i_clk,
   input  logic                                i_rst_n,
   input  logic                                i_cmd_valid,
   output logic                                o_cmd_ready,
   input  logic [1:0]                          i_cmd_op,
   input  logic [WORD_WIDTH-1:0]               i_cmd_data,
   input  logic [$clog2(MAX_RX_BYTES+1)-1:0]   i_cmd_len,
   output logic                                o_tx_start,
   output logic [7:0]                          o_tx_data,
   input  logic                                i_tx_done,
   input  logic                                i_rx_valid,
   input  logic [7:0]                          i_rx_data,
   output logic                                o_rx_byte_valid,
   output logic [7:0]                          o_rx_byte,
   output logic [$clog2(MAX_RX_BYTES)-1:0]     o_rx_index,
   output logic                                o_done,
   output logic                                o_timeout,
   output logic                                o_busy
);

   localparam int NB = WORD_WIDTH / 8;
   localparam int LW = $clog2(MAX_RX_BYTES + 1);
   localparam int IW = $clog2(MAX_RX_BYTES);
   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   localparam logic [LW-1:0] MAX_LEN        = LW'(MAX_RX_BYTES);
   localparam logic [LW-1:0] MAX_IDX_CNT    = LW'(MAX_RX_BYTES - 1);
   localparam logic [LW-1:0] LAST_WORD_BYTE = LW'(NB - 1);
   localparam logic [TW-1:0] TO_LIMIT       = TW'(TIMEOUT_CYCLES);
   localparam bit            TO_EN          = (TIMEOUT_CYCLES != 0);

   localparam logic [1:0] OP_SEND_BYTE  = 2'd0;
   localparam logic [1:0] OP_SEND_WORD  = 2'd1;
   localparam logic [1:0] OP_RECV_N     = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TX_REQ,
      ST_TX_GAP,
      ST_RX_COLLECT,
      ST_RX_WAIT_RDY,
      ST_DONE
   } state_t;

   state_t                state;
   logic [WORD_WIDTH-1:0] tx_shift;   // unsent bytes, next one always in [7:0]
   logic [LW-1:0]         byte_cnt;
   logic [LW-1:0]         last_cnt;   // index of the final byte of the command
   logic [TW-1:0]         to_cnt;
   logic [LW-1:0]         len_clamped;

   always_comb begin
      len_clamped = (i_cmd_len > MAX_LEN) ? MAX_LEN : i_cmd_len;
   end

   assign o_cmd_ready = (state == ST_IDLE);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state           <= ST_IDLE;
         tx_shift        <= '0;
         byte_cnt        <= '0;
         last_cnt        <= '0;
         to_cnt          <= '0;
         o_tx_start      <= 1'b0;
         o_tx_data       <= 8'h00;
         o_rx_byte_valid <= 1'b0;
         o_rx_byte       <= 8'h00;
         o_rx_index      <= '0;
         o_done          <= 1'b0;
         o_timeout       <= 1'b0;
         o_busy          <= 1'b0;
      end else begin
         o_rx_byte_valid <= 1'b0;
         o_done          <= 1'b0;
         o_timeout       <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (i_cmd_valid) begin
                  tx_shift <= i_cmd_data;
                  byte_cnt <= '0;
                  to_cnt   <= '0;
                  o_busy   <= 1'b1;
                  case (i_cmd_op)
                     OP_SEND_BYTE, OP_SEND_WORD: begin
                        last_cnt   <= (i_cmd_op == OP_SEND_WORD) ? LAST_WORD_BYTE : '0;
                        o_tx_start <= 1'b1;
                        o_tx_data  <= i_cmd_data[7:0];
                        state      <= ST_TX_REQ;
                     end
                     OP_RECV_N: begin
                        if (len_clamped == '0) begin
                           o_done <= 1'b1;
                           state  <= ST_DONE;
                        end else begin
                           last_cnt <= len_clamped - LW'(1);
                           state    <= ST_RX_COLLECT;
                        end
                     end
                     default: state <= ST_RX_WAIT_RDY;
                  endcase
               end
            end

            ST_TX_REQ: begin
               if (i_tx_done) begin
                  o_tx_start <= 1'b0;
                  if (byte_cnt == last_cnt) begin
                     o_done <= 1'b1;
                     state  <= ST_DONE;
                  end else begin
                     byte_cnt <= byte_cnt + LW'(1);
                     tx_shift <= tx_shift >> 8;
                     state    <= ST_TX_GAP;
                  end
               end
            end

            // One idle cycle so uart_tx sees a fresh rising start per byte.
            ST_TX_GAP: begin
               o_tx_start <= 1'b1;
               o_tx_data  <= tx_shift[7:0];
               state      <= ST_TX_REQ;
            end

            ST_RX_COLLECT, ST_RX_WAIT_RDY: begin
               // A byte on the expiry cycle takes priority over the timeout.
               if (i_rx_valid) begin
                  to_cnt          <= '0;
                  o_rx_byte_valid <= 1'b1;
                  o_rx_byte       <= i_rx_data;
                  o_rx_index      <= byte_cnt[IW-1:0];
                  if (state == ST_RX_COLLECT) begin
                     if (byte_cnt == last_cnt) begin
                        o_done <= 1'b1;
                        state  <= ST_DONE;
                     end else begin
                        byte_cnt <= byte_cnt + LW'(1);
                     end
                  end else begin
                     if (byte_cnt != MAX_IDX_CNT)
                        byte_cnt <= byte_cnt + LW'(1);
                     if (i_rx_data == READY_CHAR) begin
                        o_done <= 1'b1;
                        state  <= ST_DONE;
                     end
                  end
               end else if (TO_EN && (to_cnt == TO_LIMIT)) begin
                  o_done    <= 1'b1;
                  o_timeout <= 1'b1;
                  state     <= ST_DONE;
               end else if (TO_EN) begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end

            ST_DONE: begin
               o_busy <= 1'b0;
               state  <= ST_IDLE;
            end

            default: begin
               o_tx_start <= 1'b0;
               o_busy     <= 1'b0;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_host_sequencer.sv
// tb/tb_uart_host_sequencer.sv - directed self-checking bench for uart_host_sequencer

module tb_uart_host_sequencer;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [31:0] cmd_data;
   logic [7:0] cmd_len;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_done;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_byte_valid;
   logic [7:0] rx_byte;
   logic [6:0] rx_index;
   logic       done;
   logic       timeout;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   uart_host_sequencer #(
      .WORD_WIDTH    (32),
      .MAX_RX_BYTES  (128),
      .READY_CHAR    (8'h52),
      .TIMEOUT_CYCLES(1000)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_cmd_valid    (cmd_valid),
      .o_cmd_ready    (cmd_ready),
      .i_cmd_op       (cmd_op),
      .i_cmd_data     (cmd_data),
      .i_cmd_len      (cmd_len),
      .o_tx_start     (tx_start),
      .o_tx_data      (tx_data),
      .i_tx_done      (tx_done),
      .i_rx_valid     (rx_valid),
      .i_rx_data      (rx_data),
      .o_rx_byte_valid(rx_byte_valid),
      .o_rx_byte      (rx_byte),
      .o_rx_index     (rx_index),
      .o_done         (done),
      .o_timeout      (timeout),
      .o_busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Returns on the falling edge right after the accepting rising edge.
   task automatic issue(input logic [1:0] op, input logic [31:0] data, input logic [7:0] len);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!cmd_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      cmd_len   = len;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Drives one received byte and returns on the falling edge where the forward is visible.
   task automatic rx_push(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] word_bytes [4];
      logic [7:0] rx_bytes [4];
      logic [7:0] rdy_bytes [3];
      bit         held_bad;
      bit         saw_done;
      int         k;

      word_bytes = '{8'h06, 8'h00, 8'h01, 8'h20};
      rx_bytes   = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      rdy_bytes  = '{8'h41, 8'h00, 8'h52};

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = '0; cmd_len = '0;
      tx_done = 1'b0; rx_valid = 1'b0; rx_data = '0;
      repeat (3) @(negedge clk);
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_tx_data",  32'(tx_data),  32'd0);
      check("rst_rx_valid", 32'(rx_byte_valid), 32'd0);
      check("rst_rx_index", 32'(rx_index), 32'd0);
      check("rst_done",     32'(done),     32'd0);
      check("rst_busy",     32'(busy),     32'd0);
      check("rst_ready",    32'(cmd_ready), 32'd1);
      rst_n = 1'b1;

      // SEND_WORD, LSB first, one gap cycle between bytes.
      issue(2'd1, 32'h20010006, 8'd0);
      check("sw_busy", 32'(busy), 32'd1);
      for (int b = 0; b < 4; b++) begin
         check($sformatf("sw_start%0d", b), 32'(tx_start), 32'd1);
         check($sformatf("sw_data%0d", b),  32'(tx_data), 32'(word_bytes[b]));
         held_bad = 1'b0;
         repeat (9) begin
            @(negedge clk);
            if (!tx_start || tx_data !== word_bytes[b] || done) held_bad = 1'b1;
         end
         check($sformatf("sw_held%0d", b), 32'(held_bad), 32'd0);
         tx_done = 1'b1;
         @(negedge clk);
         tx_done = 1'b0;
         check($sformatf("sw_gap%0d", b), 32'(tx_start), 32'd0);
         if (b < 3) begin
            check($sformatf("sw_nodone%0d", b), 32'(done), 32'd0);
            @(negedge clk);
         end else begin
            check("sw_done",    32'(done),    32'd1);
            check("sw_timeout", 32'(timeout), 32'd0);
         end
      end
      @(negedge clk);
      check("sw_done_pulse", 32'(done), 32'd0);
      check("sw_ready_back", 32'(cmd_ready), 32'd1);

      // SEND_BYTE sends only the low byte.
      issue(2'd0, 32'h123456A5, 8'd0);
      check("sb_data", 32'(tx_data), 32'hA5);
      @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      check("sb_done", 32'(done), 32'd1);

      // RECV_N 4
      issue(2'd2, 32'd0, 8'd4);
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         rx_push(rx_bytes[b]);
         check($sformatf("rn_valid%0d", b), 32'(rx_byte_valid), 32'd1);
         check($sformatf("rn_byte%0d", b),  32'(rx_byte), 32'(rx_bytes[b]));
         check($sformatf("rn_idx%0d", b),   32'(rx_index), 32'(b));
         check($sformatf("rn_done%0d", b),  32'(done), 32'(b == 3));
      end
      @(negedge clk);
      rx_push(8'hEE);
      check("rn_fifth_ignored", 32'(rx_byte_valid), 32'd0);

      // WAIT_READY
      issue(2'd3, 32'd0, 8'd0);
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         rx_push(rdy_bytes[b]);
         check($sformatf("wr_valid%0d", b), 32'(rx_byte_valid), 32'd1);
         check($sformatf("wr_idx%0d", b),   32'(rx_index), 32'(b));
         check($sformatf("wr_done%0d", b),  32'(done), 32'(b == 2));
      end
      check("wr_timeout", 32'(timeout), 32'd0);

      // Timeout: no input, done 1001 clocks after the accept edge.
      issue(2'd3, 32'd0, 8'd0);
      k = 0;
      while (!done && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check("to_latency", 32'(k), 32'd1001);
      check("to_flag",    32'(timeout), 32'd1);

      // Byte on the expiry cycle beats the timeout.
      issue(2'd3, 32'd0, 8'd0);
      saw_done = 1'b0;
      repeat (1000) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      rx_push(8'h41);
      check("tr_no_early_done", 32'(saw_done), 32'd0);
      check("tr_byte_wins",     32'(rx_byte_valid), 32'd1);
      check("tr_no_timeout",    32'(done), 32'd0);
      @(negedge clk);
      rx_push(8'h52);
      check("tr_done",       32'(done), 32'd1);
      check("tr_timeout_lo", 32'(timeout), 32'd0);

      // RECV_N len=0
      issue(2'd2, 32'd0, 8'd0);
      check("l0_done",    32'(done), 32'd1);
      check("l0_timeout", 32'(timeout), 32'd0);

      // RECV_N oversized len clamps to 128 bytes.
      issue(2'd2, 32'd0, 8'd133);
      saw_done = 1'b0;
      for (int b = 0; b < 128; b++) begin
         @(negedge clk);
         rx_push(8'(b));
         if (b < 127 && done) saw_done = 1'b1;
      end
      check("cl_no_early_done", 32'(saw_done), 32'd0);
      check("cl_last_idx", 32'(rx_index), 32'd127);
      check("cl_done",     32'(done), 32'd1);

      // Reset during the third byte of SEND_WORD.
      issue(2'd1, 32'h11223344, 8'd0);
      for (int b = 0; b < 2; b++) begin
         @(negedge clk);
         tx_done = 1'b1;
         @(negedge clk);
         tx_done = 1'b0;
         @(negedge clk);
      end
      check("rs_third_start", 32'(tx_start), 32'd1);
      check("rs_third_data",  32'(tx_data), 32'h22);
      #2 rst_n = 1'b0;
      #1;
      check("rs_async_start", 32'(tx_start), 32'd0);
      check("rs_async_busy",  32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check("rs_ready", 32'(cmd_ready), 32'd1);
      saw_done = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done || tx_start) saw_done = 1'b1;
      end
      check("rs_no_done", 32'(saw_done), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
